// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer: FSM states,
// opcode values and the instruction field positions.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_EXCH = 4'b1011;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_SET  = 4'b1101;
  localparam logic [3:0] OP_CLR  = 4'b1110;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RA_MSB = 7;
  localparam int RA_LSB = 4;
  localparam int RB_MSB = 3;
  localparam int RB_LSB = 0;

endpackage

// File: rtl/alu_wb_decode.sv
// Combinational writeback decode: maps an opcode to register-file and
// status-register write enables. Gating by the WB state is done by the parent.
module alu_wb_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       rf_we_a,
  output logic       rf_we_b,
  output logic       psw_we
);

  // NOTE: every output gets a default before the case so no latch can be inferred.
  always_comb begin
    rf_we_a = 1'b0;
    rf_we_b = 1'b0;
    psw_we  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_SHR: begin
        rf_we_a = 1'b1;
        psw_we  = 1'b1;
      end
      OP_MOV:  rf_we_b = 1'b1;
      OP_EXCH: begin
        rf_we_a = 1'b1;
        rf_we_b = 1'b1;
      end
      OP_CMP, OP_SET, OP_CLR: psw_we = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute/writeback sequencer driving an external ALU and register file.
// Define ALU_SEQ_RETIRE_CNT_EN to build the retired-instruction counter.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        inst_req,
  output logic [15:0] inst_addr,
  input  logic        inst_ack,
  input  logic [15:0] inst_data,
  output logic [15:0] alu_inst,
  output logic [3:0]  rf_addr_a,
  output logic [3:0]  rf_addr_b,
  output logic        rf_we_a,
  output logic        rf_we_b,
  output logic        psw_we,
  output logic        busy,
  output logic [15:0] retired
);

  state_t      state, state_next;
  logic [15:0] pc;
  logic [15:0] inst_q;
  logic        ack_take;
  logic        wb_active;
  logic        dec_we_a, dec_we_b, dec_psw_we;

  assign ack_take = (state == ST_FETCH) && inst_ack;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (run) state_next = ST_FETCH;
      ST_FETCH: if (inst_ack) state_next = ST_EXEC;
      ST_EXEC:  state_next = ST_WB;
      ST_WB:    state_next = run ? ST_FETCH : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= PC_RESET;
      inst_q <= 16'h0000;
    end else if (ack_take) begin
      pc     <= pc + 16'd1;
      inst_q <= inst_data;
    end
  end

  alu_wb_decode u_wb_decode (
    .opcode  (inst_q[OP_MSB:OP_LSB]),
    .rf_we_a (dec_we_a),
    .rf_we_b (dec_we_b),
    .psw_we  (dec_psw_we)
  );

  // Reset also masks a WB already in progress so no write escapes the reset cycle.
  assign wb_active = (state == ST_WB) && !rst;

  assign rf_we_a   = wb_active && dec_we_a;
  assign rf_we_b   = wb_active && dec_we_b;
  assign psw_we    = wb_active && dec_psw_we;
  assign inst_req  = (state == ST_FETCH);
  assign inst_addr = pc;
  assign alu_inst  = inst_q;
  assign rf_addr_a = inst_q[RA_MSB:RA_LSB];
  assign rf_addr_b = inst_q[RB_MSB:RB_LSB];
  assign busy      = (state != ST_IDLE);

`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst)                 retired_q <= 16'h0000;
    else if (state == ST_WB) retired_q <= retired_q + 16'd1;
  end

  assign retired = retired_q;
`else
  assign retired = 16'h0000;
`endif

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset: clk, rst.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- run  in  1  level; 1 = fetch and execute, 0 = stop at the next instruction boundary
- inst_req  out  1  instruction fetch request
- inst_addr  out  16  fetch address (PC)
- inst_ack  in  1  fetch data valid this cycle
- inst_data  in  16  fetched instruction
- alu_inst  out  16  latched instruction driven to the ALU
- rf_addr_a  out  4  register A select = inst[7:4]
- rf_addr_b  out  4  register B select = inst[3:0]
- rf_we_a  out  1  write ALU register A result
- rf_we_b  out  1  write ALU register B result
- psw_we  out  1  write ALU Z/N/C into the status register
- busy  out  1  state != IDLE
- retired  out  16  retired-instruction count (macro-gated, REQ-019)

Function
REQ-003 SHALL implement states IDLE, FETCH, EXEC and WB, encoded in 2 bits.
REQ-004 IDLE -> FETCH when run=1; otherwise stay in IDLE.
REQ-005 In FETCH, SHALL hold inst_req=1 and inst_addr=PC until inst_ack=1; on ack, latch inst_data into alu_inst, increment PC (16-bit wrap, 0xFFFF -> 0x0000) and go to EXEC.
REQ-006 inst_req SHALL drop in the cycle after ack; a fetch, once issued, SHALL NOT be abandoned even if run falls.
REQ-007 EXEC SHALL last exactly one cycle, with alu_inst and rf_addr_a/b stable, then go to WB.
REQ-008 In WB, write enables SHALL be pulsed for exactly one cycle, decoded from alu_inst[15:12]:
- 0100-1001 (ADD, SUB, OR, AND, XOR, SHR): rf_we_a=1, psw_we=1
- 1010 (MOV): rf_we_b=1
- 1011 (EXCH): rf_we_a=1, rf_we_b=1
- 1100-1110 (CMP, SET, CLR): psw_we=1
- all other opcodes: no enables
REQ-009 Write enables SHALL be 0 in every state other than WB.
REQ-010 From WB, SHALL go to FETCH if run=1, else to IDLE.
REQ-011 Latency: inst_ack at cycle N -> EXEC at N+1 -> WB at N+2 -> next inst_req at N+3; throughput is one instruction per 3 cycles when ack is immediate.
REQ-012 Non-ALU opcodes SHALL still pass through EXEC and WB, with no enables asserted.
REQ-013 inst_ack while not in FETCH SHALL be ignored.

Reset
REQ-014 rst SHALL dominate every other input, including inst_ack arriving in the same cycle.
REQ-015 Reset values: state=IDLE, PC=0x0000, alu_inst=0x0000, inst_req=0, rf_we_a=0, rf_we_b=0, psw_we=0, busy=0, retired=0.
REQ-016 Reset in EXEC or WB SHALL cancel the pending writeback, so no enable pulses in the following cycle.

Configuration
REQ-017 Macro ALU_SEQ_RETIRE_CNT_EN SHALL gate the retired-instruction counter.
REQ-018 With ALU_SEQ_RETIRE_CNT_EN defined: retired increments by 1 in each WB cycle and wraps 0xFFFF -> 0x0000.
REQ-019 Without ALU_SEQ_RETIRE_CNT_EN: the retired port still exists, is tied to 0x0000, and no counter flops are inferred.

Structure
REQ-020 Shared package alu_seq_pkg SHALL hold:
- the state enumeration
- 4-bit opcode constants (OP_ADD=4'b0100 ... OP_CLR=4'b1110)
- the field positions for the opcode and register selects
REQ-021 Writeback decode SHALL be a combinational sub-module, alu_wb_decode (opcode in; rf_we_a, rf_we_b, psw_we out), gated by the WB state in the parent.
REQ-022 The ALU itself SHALL NOT be instantiated inside alu_sequencer.

Verification
REQ-023 Reset then run=1, inst_ack tied 1, inst_data=0x4012 (ADD A=r1, B=r2) -> inst_req at cycle 1, rf_addr_a=1, rf_addr_b=2, rf_we_a and psw_we pulse at cycle 3, PC=0x0001.
REQ-024 Sequence 0xA034 (MOV), 0xB056 (EXCH), 0xC078 (CMP), 0x0000 -> WB enables (b)=1, (a,b)=1,1, (psw)=1, none, respectively.
REQ-025 inst_ack delayed 5 cycles -> inst_req and inst_addr held steady for 5 cycles, no enables during the wait, single EXEC/WB afterward.
REQ-026 run dropped during EXEC -> WB completes, state goes to IDLE, busy=0, no further inst_req.
REQ-027 rst asserted in WB with inst 0x4012 -> no rf_we_a pulse, PC=0x0000 next cycle; PC preset near 0xFFFF and run -> PC wraps to 0x0000.
REQ-028 With ALU_SEQ_RETIRE_CNT_EN, 4 instructions -> retired=4; without the macro -> retired=0 throughout.
